uart_tx_mmio: RTL and testbench

Memory-mapped UART transmitter that answers the core's data-port accesses (addr/we/wd in, rd out) in parallel with the RAM, at its own address window. Byte writes from software are queued in a small FIFO and serialized onto a single TX line as 8N1 frames, with a programmable per-bit divisor. It is the first I/O responder on the data bus and lets test programs emit characters.

---
 rtl/uart_pkg.sv | 20 ++
 rtl/sync_fifo.sv | 53 +++++
 rtl/uart_tx_mmio.sv | 177 +++++++++++++++++
 tb/tb_uart_tx_mmio.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART TX state, register offset and STATUS bit definitions
// UART_TX_PARITY_EN adds the PARITY state for 8E1 framing.
package uart_pkg;

`ifdef UART_TX_PARITY_EN
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} uart_tx_state_e;
`else
  typedef enum logic [2:0] {IDLE, START, DATA, STOP} uart_tx_state_e;
`endif

  localparam logic [1:0] UART_TXDATA = 2'd0;
  localparam logic [1:0] UART_STATUS = 2'd1;
  localparam logic [1:0] UART_DIV    = 2'd2;

  localparam int UART_ST_FULL  = 0;
  localparam int UART_ST_EMPTY = 1;
  localparam int UART_ST_BUSY  = 2;
  localparam int UART_ST_OVF   = 3;

endpackage

// File: rtl/sync_fifo.sv
// rtl/sync_fifo.sv - single-clock FIFO with occupancy counter; push when full and pop when empty are ignored
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wptr;
  logic [AW-1:0]    rptr;
  logic [AW:0]      count;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == FULL_CNT);
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = mem[rptr];

  // Power-of-two depth lets the pointers wrap naturally.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (do_push) wptr <= wptr + 1'b1;
      if (do_pop)  rptr <= rptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wptr] <= din;
  end

endmodule

// File: rtl/uart_tx_mmio.sv
// rtl/uart_tx_mmio.sv - memory-mapped UART transmitter: register decode, TX FIFO, bit timer and frame FSM
// Define UART_TX_PARITY_EN for 8E1 frames; default build sends 8N1.
module uart_tx_mmio
  import uart_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR   = 32'h1000_0000,
  parameter int          FIFO_DEPTH  = 8,
  parameter logic [15:0] DEFAULT_DIV = 16'd16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] addr,
  input  logic        we,
  input  logic [31:0] wd,
  output logic [31:0] rd,
  output logic        sel,
  output logic        txd
);

  uart_tx_state_e state;
  logic [1:0]  off;
  logic        wr;
  logic        push_req;
  logic        pop;
  logic        fifo_full;
  logic        fifo_empty;
  logic [7:0]  fifo_dout;
  logic [15:0] div_reg;
  logic [15:0] div_act;
  logic [15:0] timer;
  logic [7:0]  shreg;
  logic [2:0]  bit_cnt;
  logic        par;
  logic        ovf;
  logic        busy;
  logic        bit_end;
  logic        unused_bits;

  assign off         = addr[3:2];
  assign sel         = (addr[31:4] == BASE_ADDR[31:4]);
  assign wr          = sel && we;
  assign push_req    = wr && (off == UART_TXDATA);
  assign busy        = (state != IDLE);
  assign bit_end     = (timer == 16'd0);
  assign pop         = !fifo_empty && ((state == IDLE) || ((state == STOP) && bit_end));
  assign unused_bits = ^{wd[31:16], addr[1:0]};

  sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push_req),
    .pop   (pop),
    .din   (wd[7:0]),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  always_comb begin
    rd = '0;
    if (sel) begin
      case (off)
        UART_STATUS: begin
          rd[UART_ST_FULL]  = fifo_full;
          rd[UART_ST_EMPTY] = fifo_empty;
          rd[UART_ST_BUSY]  = busy;
          rd[UART_ST_OVF]   = ovf;
        end
        UART_DIV: rd = {16'd0, div_reg};
        default:  rd = '0;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_reg <= DEFAULT_DIV;
      ovf     <= 1'b0;
    end else begin
      if (wr && (off == UART_DIV))
        div_reg <= (wd[15:0] == 16'd0) ? 16'd1 : wd[15:0];
      // full is sampled before this edge, so a concurrent pop never rescues the push
      if (push_req && fifo_full)
        ovf <= 1'b1;
      else if (wr && (off == UART_STATUS) && wd[UART_ST_OVF])
        ovf <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      txd     <= 1'b1;
      timer   <= '0;
      div_act <= '0;
      shreg   <= '0;
      bit_cnt <= '0;
      par     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (pop) begin
            state   <= START;
            shreg   <= fifo_dout;
            par     <= ^fifo_dout;
            div_act <= div_reg;
            timer   <= div_reg - 16'd1;
            txd     <= 1'b0;
          end
        end
        START: begin
          if (bit_end) begin
            state   <= DATA;
            txd     <= shreg[0];
            timer   <= div_act - 16'd1;
            bit_cnt <= 3'd0;
          end else begin
            timer <= timer - 16'd1;
          end
        end
        DATA: begin
          if (bit_end) begin
            timer <= div_act - 16'd1;
            if (bit_cnt == 3'd7) begin
`ifdef UART_TX_PARITY_EN
              state <= PARITY;
              txd   <= par;
`else
              state <= STOP;
              txd   <= 1'b1;
`endif
            end else begin
              bit_cnt <= bit_cnt + 3'd1;
              shreg   <= shreg >> 1;
              txd     <= shreg[1];
            end
          end else begin
            timer <= timer - 16'd1;
          end
        end
`ifdef UART_TX_PARITY_EN
        PARITY: begin
          if (bit_end) begin
            state <= STOP;
            txd   <= 1'b1;
            timer <= div_act - 16'd1;
          end else begin
            timer <= timer - 16'd1;
          end
        end
`endif
        STOP: begin
          if (bit_end) begin
            // Chain straight into the next start bit when another byte is waiting.
            if (pop) begin
              state   <= START;
              shreg   <= fifo_dout;
              par     <= ^fifo_dout;
              div_act <= div_reg;
              timer   <= div_reg - 16'd1;
              txd     <= 1'b0;
            end else begin
              state <= IDLE;
            end
          end else begin
            timer <= timer - 16'd1;
          end
        end
        default: begin
          state <= IDLE;
          txd   <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_mmio.sv
// tb/tb_uart_tx_mmio.sv - self-checking bench for uart_tx_mmio: register vector table plus serial frame sequences
`timescale 1ns/1ps
module tb_uart_tx_mmio;

  localparam logic [31:0] B = 32'h1000_0000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] addr = 32'd0;
  logic        we = 1'b0;
  logic [31:0] wd = 32'd0;
  logic [31:0] rd;
  logic        sel;
  logic        txd;

  int checks = 0;
  int errors = 0;
  logic exp_q[$];
  bit mon_on = 1'b0;

  typedef struct {
    logic [31:0] addr;
    logic        we;
    logic [31:0] wd;
    logic        exp_sel;
    logic [31:0] exp_rd;
  } vec_t;

  vec_t vecs[14];

  uart_tx_mmio #(.BASE_ADDR(B), .FIFO_DEPTH(8), .DEFAULT_DIV(16'd16)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .addr  (addr),
    .we    (we),
    .wd    (wd),
    .rd    (rd),
    .sel   (sel),
    .txd   (txd)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog timeout checks=%0d errors=%0d", checks, errors);
    $fatal(1, "timeout");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: actual=%h required=%h", name, $time, act, exp);
    end
  endtask

  function automatic void add_frame(input logic [7:0] b, input int div);
    for (int k = 0; k < div; k++) exp_q.push_back(1'b0);
    for (int i = 0; i < 8; i++)
      for (int k = 0; k < div; k++) exp_q.push_back(b[i]);
`ifdef UART_TX_PARITY_EN
    for (int k = 0; k < div; k++) exp_q.push_back(^b);
`endif
    for (int k = 0; k < div; k++) exp_q.push_back(1'b1);
  endfunction

  // One clock: drive on the falling edge, sample 1ns after the rising edge.
  task automatic cyc(input logic [31:0] a, input logic w, input logic [31:0] d);
    logic exp_txd;
    logic exp_busy;
    @(negedge clk);
    addr = a;
    we   = w;
    wd   = d;
    @(posedge clk);
    #1;
    we = 1'b0;
    if (mon_on) begin
      if (exp_q.size() > 0) begin
        exp_txd  = exp_q.pop_front();
        exp_busy = 1'b1;
      end else begin
        exp_txd  = 1'b1;
        exp_busy = 1'b0;
      end
      check("txd", {31'd0, txd}, {31'd0, exp_txd});
      check("busy", {31'd0, dut.busy}, {31'd0, exp_busy});
    end
  endtask

  task automatic drain();
    int guard = 0;
    while (exp_q.size() > 0 && guard < 3000) begin
      cyc(B + 32'h4, 1'b0, 32'd0);
      guard++;
    end
    if (exp_q.size() > 0) begin
      errors++;
      $display("FAIL drain_timeout remaining=%0d required=0", exp_q.size());
      exp_q.delete();
    end
  endtask

  initial begin
    vecs[0]  = '{B + 32'h4,    1'b0, 32'd0,          1'b1, 32'h2};
    vecs[1]  = '{B + 32'h8,    1'b0, 32'd0,          1'b1, 32'd16};
    vecs[2]  = '{B + 32'h0,    1'b0, 32'd0,          1'b1, 32'd0};
    vecs[3]  = '{B + 32'hC,    1'b1, 32'hFFFF_FFFF,  1'b1, 32'd0};
    vecs[4]  = '{B + 32'h4,    1'b0, 32'd0,          1'b1, 32'h2};
    vecs[5]  = '{B + 32'h8,    1'b0, 32'd0,          1'b1, 32'd16};
    vecs[6]  = '{B + 32'h8,    1'b1, 32'd0,          1'b1, 32'd1};
    vecs[7]  = '{B + 32'h8,    1'b1, 32'hABCD_1234,  1'b1, 32'h1234};
    vecs[8]  = '{32'h2000_0008, 1'b1, 32'd7,         1'b0, 32'd0};
    vecs[9]  = '{B + 32'h8,    1'b0, 32'd0,          1'b1, 32'h1234};
    vecs[10] = '{B + 32'h10,   1'b0, 32'd0,          1'b0, 32'd0};
    vecs[11] = '{32'h0FFF_FFFC, 1'b0, 32'd0,         1'b0, 32'd0};
    vecs[12] = '{B + 32'h4,    1'b1, 32'h8,          1'b1, 32'h2};
    vecs[13] = '{B + 32'h8,    1'b1, 32'd4,          1'b1, 32'd4};

    #23;
    check("reset_txd", {31'd0, txd}, 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    mon_on = 1'b1;

    for (int i = 0; i < 14; i++) begin
      cyc(vecs[i].addr, vecs[i].we, vecs[i].wd);
      check($sformatf("vec%0d_sel", i), {31'd0, sel}, {31'd0, vecs[i].exp_sel});
      check($sformatf("vec%0d_rd", i), rd, vecs[i].exp_rd);
    end

    // Single 0x55 frame at DIV=4.
    cyc(B, 1'b1, 32'h55);
    add_frame(8'h55, 4);
    drain();
    repeat (3) cyc(B + 32'h4, 1'b0, 32'd0);

    // Nine back-to-back bytes at DIV=2, then overflow and clear.
    cyc(B + 32'h8, 1'b1, 32'd2);
    for (int i = 0; i < 9; i++) begin
      cyc(B, 1'b1, 32'(i));
      add_frame(8'(i), 2);
    end
    cyc(B + 32'h4, 1'b0, 32'd0);
    check("b2b_status_full", rd, 32'h5);
    cyc(B, 1'b1, 32'h09);
    cyc(B + 32'h4, 1'b0, 32'd0);
    check("b2b_status_ovf", rd, 32'hD);
    cyc(B + 32'h4, 1'b1, 32'h8);
    cyc(B + 32'h4, 1'b0, 32'd0);
    check("b2b_status_clr", rd, 32'h5);
    drain();
    repeat (10) cyc(B + 32'h4, 1'b0, 32'd0);
    check("b2b_status_end", rd, 32'h2);

    // DIV change mid-frame applies only to the next frame.
    cyc(B + 32'h8, 1'b1, 32'd4);
    cyc(B, 1'b1, 32'hA5);
    add_frame(8'hA5, 4);
    repeat (3) cyc(B + 32'h4, 1'b0, 32'd0);
    cyc(B + 32'h8, 1'b1, 32'd2);
    cyc(B, 1'b1, 32'h3C);
    add_frame(8'h3C, 2);
    cyc(B + 32'h8, 1'b0, 32'd0);
    check("mid_div_readback", rd, 32'd2);
    drain();
    repeat (5) cyc(B + 32'h4, 1'b0, 32'd0);

    // Reset in the middle of DATA with a byte still queued.
    cyc(B + 32'h8, 1'b1, 32'd4);
    mon_on = 1'b0;
    cyc(B, 1'b1, 32'h00);
    cyc(B, 1'b1, 32'h00);
    repeat (12) cyc(B + 32'h4, 1'b0, 32'd0);
    check("pre_reset_txd", {31'd0, txd}, 32'd0);
    check("pre_reset_status", rd, 32'h4);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_reset_txd", {31'd0, txd}, 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    mon_on = 1'b1;
    cyc(B + 32'h4, 1'b0, 32'd0);
    check("post_reset_status", rd, 32'h2);
    repeat (60) cyc(B + 32'h4, 1'b0, 32'd0);
    cyc(B + 32'h8, 1'b0, 32'd0);
    check("post_reset_div", rd, 32'd16);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
